mult_div_unit: RTL and testbench

- Iterative, parametrised HI/LO multiply/divide unit for the MIPS datapath; successor to the single-cycle combinational multiplier.
- Supports signed/unsigned multiply and divide with a start/busy/done handshake.
- Architectural HI/LO registers live inside the block; MTHI/MTLO write ports are included.
- The pipeline stalls on busy before any MFHI/MFLO.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mult_div_unit_datapath.sv | 84 ++++++++
 rtl/mult_div_unit.sv | 92 +++++++++
 tb/tb_mult_div_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS HI/LO multiply/divide unit.
package mips_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

endpackage

// File: rtl/mult_div_unit_datapath.sv
// Accumulator, one-bit shift-add / restoring shift-subtract step and sign fix-up.
module mdu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0]   acc_hi, acc_lo, m;
    logic               neg_res, neg_rem, div_q;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo;
    logic [WIDTH:0]     sum, sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there.
    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    assign sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign diff = {1'b0, sh} - {2'b00, m};

    always_comb begin
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        if (!div_q) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            nxt_hi = diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = sh[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    assign prod = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

    always_comb begin
        if (div_q) begin
            res_hi = neg_rem ? -acc_hi : acc_hi;
            res_lo = neg_res ? -acc_lo : acc_lo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            m       <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div_q   <= 1'b0;
        end else if (load) begin
            acc_hi  <= '0;
            acc_lo  <= is_div ? a_abs : b_abs;
            m       <= is_div ? b_abs : a_abs;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div_q   <= is_div;
        end else if (step) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: FSM, iteration counter and HI/LO registers.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             dz_pend;
    logic             load, step, is_div, is_signed;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign busy      = (state != ST_IDLE);
    assign load      = (state == ST_IDLE) && start;
    assign step      = (state == ST_CALC);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    mdu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dz_pend     <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dz_pend <= is_div && (b == '0);
                        cnt     <= '0;
                        state   <= ST_CALC;
                    end else begin
                        if (hi_we) hi <= hi_wdata;
                        if (lo_we) lo <= lo_wdata;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    // A zero divisor still runs full latency but leaves HI/LO alone.
                    if (!dz_pend) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                    done        <= 1'b1;
                    div_by_zero <= dz_pend;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus random ops vs a plain-arithmetic model.
module tb_mult_div_unit;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [1:0]  op = 0;
    logic [31:0] a = 0, b = 0;
    logic        hi_we = 0, lo_we = 0;
    logic [31:0] hi_wdata = 0, lo_wdata = 0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [31:0] mhi = 0, mlo = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each done pulse against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", {32'h0, hi}, {32'h0, e.hi});
                chk("lo", {32'h0, lo}, {32'h0, e.lo});
                chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dz});
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("busy_cycles", 64'(busy_cnt), 64'd33);
                chk("busy_after_done", {63'h0, busy}, 64'd0);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    // Reference: full-width signed/unsigned arithmetic on 64-bit integers.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sx, sy, p, q, r;
        logic [63:0] pb, qb, rb;
        if (o[0]) begin
            sx = longint'({32'h0, x});
            sy = longint'({32'h0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        eh = mhi;
        el = mlo;
        ed = 1'b0;
        if (!o[1]) begin
            p  = sx * sy;
            pb = p;
            eh = pb[63:32];
            el = pb[31:0];
        end else if (y == 0) begin
            ed = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            qb = q;
            rb = r;
            el = qb[31:0];
            eh = rb[31:0];
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed);
        exp_t e;
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 0;
        e.hi = eh; e.lo = el; e.dz = ed; e.cyc = cyc + 33;
        sb.push_back(e);
        mhi = eh;
        mlo = el;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 60) chk("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed);
        issue(o, x, y, eh, el, ed);
        wait_done();
    endtask

    task automatic run_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        logic ed;
        model(o, x, y, eh, el, ed);
        run(o, x, y, eh, el, ed);
    endtask

    task automatic mt(input logic hw, input logic [31:0] hd, input logic lw, input logic [31:0] ld);
        @(negedge clk);
        hi_we = hw; hi_wdata = hd; lo_we = lw; lo_wdata = ld;
        @(posedge clk);
        #1;
        hi_we = 0; lo_we = 0;
        if (hw) mhi = hd;
        if (lw) mlo = ld;
        @(negedge clk);
        chk("mt_hi", {32'h0, hi}, {32'h0, mhi});
        chk("mt_lo", {32'h0, lo}, {32'h0, mlo});
    endtask

    logic [31:0] specials [6];

    initial begin
        specials[0] = 32'h0;
        specials[1] = 32'h1;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        specials[5] = 32'h2;

        #12;
        chk("rst_hi", {32'h0, hi}, 64'd0);
        chk("rst_lo", {32'h0, lo}, 64'd0);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_dz", {63'h0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        run(2'b01, 32'd10, 32'd10, 32'h0, 32'd100, 1'b0);
        run(2'b00, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        run(2'b01, 32'd5, 32'hFFFF_FFFF, 32'h4, 32'hFFFF_FFFB, 1'b0);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(2'b11, 32'd5, 32'd3, 32'd2, 32'd1, 1'b0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        mt(1'b1, 32'h1234, 1'b1, 32'h5678);
        run(2'b11, 32'd10, 32'd0, 32'h1234, 32'h5678, 1'b1);
        repeat (3) @(negedge clk);
        chk("dz_hold", {63'h0, div_by_zero}, 64'd1);

        // Start while busy: second start must vanish.
        issue(2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);
        repeat (4) @(negedge clk);
        start = 1; a = 32'd7; b = 32'd7;
        @(negedge clk);
        start = 0;
        wait_done();
        repeat (40) @(negedge clk);

        // Reset mid-operation.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        void'(sb.pop_back());
        repeat (10) @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort_busy", {63'h0, busy}, 64'd0);
        chk("abort_hi", {32'h0, hi}, 64'd0);
        chk("abort_lo", {32'h0, lo}, 64'd0);
        mhi = 0; mlo = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);
        chk("abort_no_done_busy", {63'h0, busy}, 64'd0);
        run(2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

        // Write priority: start beats hi_we, MT while busy ignored.
        mt(1'b1, 32'hAAAA, 1'b0, 32'h0);
        @(negedge clk);
        start = 1; op = 2'b01; a = 32'd6; b = 32'd7;
        hi_we = 1; hi_wdata = 32'hDEAD;
        begin
            exp_t e;
            @(posedge clk);
            #1;
            start = 0;
            e.hi = 32'h0; e.lo = 32'd42; e.dz = 1'b0; e.cyc = cyc + 33;
            sb.push_back(e);
        end
        hi_wdata = 32'hBEEF; lo_we = 1; lo_wdata = 32'hBEEF;
        repeat (10) @(negedge clk);
        chk("mt_while_busy_hi", {32'h0, hi}, 64'hAAAA);
        hi_we = 0; lo_we = 0;
        wait_done();
        mhi = 32'h0; mlo = 32'd42;
        mt(1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0002);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = $urandom();
            y = $urandom();
            if ($urandom_range(0, 4) == 0) x = specials[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) y = specials[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) y = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mt(1'b1, $urandom(), 1'b1, $urandom());
            run_model(o, x, y);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
